// File: rtl/conv3x3_engine.sv
// conv3x3_engine: 3x3 spatial convolution over a 32x32 signed int8 tensor.
// On a tensor_valid pulse the block sweeps every output pixel in raster order,
// reading the nine neighbours through a 1-cycle-latency RAM port. It
// accumulates tap products, shifts and saturates the result to int8, and
// writes it to the heatmap RAM. It pulses heatmap_valid when the sweep ends.
//
// Ports:
//   clk           pixel clock
//   reset         asynchronous, active-high
//   tensor_valid  pulse: input tensor complete (starts a sweep when idle)
//   raddr         tensor read address {y, x}
//   rdata         signed tensor data, one cycle after raddr
//   out_we        heatmap write enable (one cycle per pixel)
//   out_waddr     heatmap address {v, u}
//   out_wdata     signed saturated result
//   heatmap_valid pulse: heatmap complete
//   busy          sweep in progress
//   frame_drop    pulse: tensor_valid ignored while busy
module conv3x3_engine #(
    parameter logic [71:0] KERNEL = 72'h00_00_00_00_10_00_00_00_00,
    parameter int unsigned SHIFT  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tensor_valid,
    output logic [9:0] raddr,
    input  logic [7:0] rdata,
    output logic       out_we,
    output logic [9:0] out_waddr,
    output logic [7:0] out_wdata,
    output logic       heatmap_valid,
    output logic       busy,
    output logic       frame_drop
);

    typedef enum logic [2:0] {StIdle, StRead, StDrain, StWrite, StDone} state_e;

    state_e             state_q;
    logic        [4:0]  u_q, v_q;
    logic        [3:0]  tap_q;
    logic        [9:0]  raddr_q;
    logic               pad_q;
    // Tap index / pad flag of the read whose data is on rdata this cycle.
    logic               mac_vld_q;
    logic        [3:0]  mac_tap_q;
    logic               mac_pad_q;
    logic signed [19:0] acc_q;
    logic               out_we_q;
    logic        [9:0]  out_waddr_q;
    logic        [7:0]  out_wdata_q;
    logic               hv_q;
    logic               fd_q;

    // Next read to issue.
    logic        [4:0]  iss_u, iss_v;
    logic        [3:0]  iss_tap;
    logic        [1:0]  col, row;
    logic        [5:0]  nx, ny;
    logic               iss_pad;
    logic        [9:0]  iss_addr;

    always_comb begin
        iss_u   = 5'd0;
        iss_v   = 5'd0;
        iss_tap = 4'd0;
        if (state_q == StRead) begin
            iss_u   = u_q;
            iss_v   = v_q;
            iss_tap = tap_q + 4'd1;
        end else if (state_q == StWrite) begin
            iss_u   = u_q + 5'd1;
            iss_v   = (u_q == 5'd31) ? v_q + 5'd1 : v_q;
        end
        case (iss_tap)
            4'd0, 4'd3, 4'd6: col = 2'd0;
            4'd1, 4'd4, 4'd7: col = 2'd1;
            default:          col = 2'd2;
        endcase
        row = (iss_tap >= 4'd6) ? 2'd2 : (iss_tap >= 4'd3) ? 2'd1 : 2'd0;
        // 6-bit coordinate: -1 wraps to 63 and 32 sets bit 5, so bit 5 flags padding.
        nx       = {1'b0, iss_u} + {4'b0, col} - 6'd1;
        ny       = {1'b0, iss_v} + {4'b0, row} - 6'd1;
        iss_pad  = nx[5] | ny[5];
        iss_addr = {ny[4:0], nx[4:0]};
    end

    // Multiply-accumulate and output scaling.
    logic signed [7:0]  coef;
    logic signed [15:0] prod;
    logic signed [19:0] term;
    logic signed [19:0] acc_sum;
    logic signed [19:0] shifted;
    logic        [7:0]  sat;

    always_comb begin
        coef    = $signed(KERNEL[{mac_tap_q, 3'b000} +: 8]);
        prod    = $signed(rdata) * coef;
        term    = mac_pad_q ? 20'sd0 : {{4{prod[15]}}, prod};
        acc_sum = acc_q + term;
        shifted = acc_sum >>> SHIFT;
        if (shifted > 20'sd127) begin
            sat = 8'h7f;
        end else if (shifted < -20'sd128) begin
            sat = 8'h80;
        end else begin
            sat = shifted[7:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            u_q         <= 5'd0;
            v_q         <= 5'd0;
            tap_q       <= 4'd0;
            raddr_q     <= 10'd0;
            pad_q       <= 1'b0;
            mac_vld_q   <= 1'b0;
            mac_tap_q   <= 4'd0;
            mac_pad_q   <= 1'b0;
            acc_q       <= 20'sd0;
            out_we_q    <= 1'b0;
            out_waddr_q <= 10'd0;
            out_wdata_q <= 8'd0;
            hv_q        <= 1'b0;
            fd_q        <= 1'b0;
        end else begin
            fd_q      <= tensor_valid && (state_q != StIdle);
            out_we_q  <= 1'b0;
            hv_q      <= 1'b0;
            mac_vld_q <= (state_q == StRead);
            mac_tap_q <= tap_q;
            mac_pad_q <= pad_q;
            if (mac_vld_q) begin
                acc_q <= acc_sum;
            end
            case (state_q)
                StIdle: begin
                    if (tensor_valid) begin
                        state_q <= StRead;
                        u_q     <= 5'd0;
                        v_q     <= 5'd0;
                        tap_q   <= 4'd0;
                        raddr_q <= iss_addr;
                        pad_q   <= iss_pad;
                        acc_q   <= 20'sd0;
                    end
                end
                StRead: begin
                    if (tap_q == 4'd8) begin
                        state_q <= StDrain;
                    end else begin
                        tap_q   <= iss_tap;
                        raddr_q <= iss_addr;
                        pad_q   <= iss_pad;
                    end
                end
                StDrain: begin
                    // Last product lands this cycle; write the full sum and clear.
                    state_q     <= StWrite;
                    out_we_q    <= 1'b1;
                    out_waddr_q <= {v_q, u_q};
                    out_wdata_q <= sat;
                    acc_q       <= 20'sd0;
                end
                StWrite: begin
                    if (u_q == 5'd31 && v_q == 5'd31) begin
                        state_q <= StDone;
                        hv_q    <= 1'b1;
                    end else begin
                        state_q <= StRead;
                        u_q     <= iss_u;
                        v_q     <= iss_v;
                        tap_q   <= 4'd0;
                        raddr_q <= iss_addr;
                        pad_q   <= iss_pad;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign raddr         = raddr_q;
    assign out_we        = out_we_q;
    assign out_waddr     = out_waddr_q;
    assign out_wdata     = out_wdata_q;
    assign heatmap_valid = hv_q;
    assign frame_drop    = fd_q;
    assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_conv3x3_engine.sv
// Bench for conv3x3_engine: five instances with different kernels run in
// lockstep over their own tensor RAMs. Expected writes are queued when a sweep
// starts; a monitor pops and compares them whenever out_we is seen.
module tb_conv3x3_engine;

    localparam int ND = 5;

    logic       clk = 1'b0;
    logic       reset;
    logic       tv;
    logic [9:0] raddr     [ND];
    logic [7:0] rdata     [ND];
    logic       out_we    [ND];
    logic [9:0] out_waddr [ND];
    logic [7:0] out_wdata [ND];
    logic       hv        [ND];
    logic       busy      [ND];
    logic       fd        [ND];
    logic [7:0] mem [ND][1024];

    always #5 clk = ~clk;

    conv3x3_engine u_id (
        .clk(clk), .reset(reset), .tensor_valid(tv), .raddr(raddr[0]), .rdata(rdata[0]),
        .out_we(out_we[0]), .out_waddr(out_waddr[0]), .out_wdata(out_wdata[0]),
        .heatmap_valid(hv[0]), .busy(busy[0]), .frame_drop(fd[0])
    );
    conv3x3_engine #(.KERNEL(72'h01_01_01_01_01_01_01_01_01), .SHIFT(0)) u_box (
        .clk(clk), .reset(reset), .tensor_valid(tv), .raddr(raddr[1]), .rdata(rdata[1]),
        .out_we(out_we[1]), .out_waddr(out_waddr[1]), .out_wdata(out_wdata[1]),
        .heatmap_valid(hv[1]), .busy(busy[1]), .frame_drop(fd[1])
    );
    conv3x3_engine #(.KERNEL(72'h80_80_80_80_80_80_80_80_80), .SHIFT(0)) u_neg (
        .clk(clk), .reset(reset), .tensor_valid(tv), .raddr(raddr[2]), .rdata(rdata[2]),
        .out_we(out_we[2]), .out_waddr(out_waddr[2]), .out_wdata(out_wdata[2]),
        .heatmap_valid(hv[2]), .busy(busy[2]), .frame_drop(fd[2])
    );
    conv3x3_engine #(.KERNEL(72'h7f_7f_7f_7f_7f_7f_7f_7f_7f), .SHIFT(0)) u_pos (
        .clk(clk), .reset(reset), .tensor_valid(tv), .raddr(raddr[3]), .rdata(rdata[3]),
        .out_we(out_we[3]), .out_waddr(out_waddr[3]), .out_wdata(out_wdata[3]),
        .heatmap_valid(hv[3]), .busy(busy[3]), .frame_drop(fd[3])
    );
    conv3x3_engine #(.KERNEL(72'h00_00_00_00_01_00_00_00_00), .SHIFT(4)) u_c1 (
        .clk(clk), .reset(reset), .tensor_valid(tv), .raddr(raddr[4]), .rdata(rdata[4]),
        .out_we(out_we[4]), .out_waddr(out_waddr[4]), .out_wdata(out_wdata[4]),
        .heatmap_valid(hv[4]), .busy(busy[4]), .frame_drop(fd[4])
    );

    // Tensor RAMs with 1-cycle read latency.
    always @(posedge clk) begin
        for (int k = 0; k < ND; k++) rdata[k] <= mem[k][raddr[k]];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [9:0]  addr;
        logic [39:0] data;
    } exp_t;
    exp_t exp_q[$];

    int n_cmp = 0;
    int n_fail = 0;
    int we_cnt [ND];
    int hv_cnt [ND];
    int fd_cnt [ND];
    int first_we, last_we, hv_cyc;

    task automatic check(input string name, input int k, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s dut%0d: actual %0d required %0d", name, k, act, req);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        logic any;
        exp_t e;
        any = 1'b0;
        for (int k = 0; k < ND; k++) any |= out_we[k];
        if (any) begin
            if (exp_q.size() == 0) begin
                for (int k = 0; k < ND; k++) begin
                    n_cmp++;
                    if (out_we[k]) begin
                        n_fail++;
                        $display("FAIL unexpected_write dut%0d: actual addr %0d required none",
                                 k, out_waddr[k]);
                    end
                end
            end else begin
                e = exp_q.pop_front();
                for (int k = 0; k < ND; k++) begin
                    n_cmp++;
                    if (!out_we[k] || out_waddr[k] !== e.addr ||
                        out_wdata[k] !== e.data[k*8 +: 8]) begin
                        n_fail++;
                        $display("FAIL write dut%0d: actual we=%0d addr=%0d data=%0d required addr=%0d data=%0d",
                                 k, out_we[k], out_waddr[k], $signed(out_wdata[k]),
                                 e.addr, $signed(e.data[k*8 +: 8]));
                    end
                end
            end
        end
        for (int k = 0; k < ND; k++) begin
            if (out_we[k]) we_cnt[k]++;
            if (hv[k]) hv_cnt[k]++;
            if (fd[k]) fd_cnt[k]++;
        end
        if (out_we[0]) begin
            if (first_we < 0) first_we = cyc;
            last_we = cyc;
        end
        if (hv[0]) hv_cyc = cyc;
    end

    function automatic logic [7:0] exp_val(input int k, input int a, input bit c1_15);
        int u, v, nu, nv;
        logic [7:0] r;
        u  = a % 32;
        v  = a / 32;
        nu = (u == 0 || u == 31) ? 2 : 3;
        nv = (v == 0 || v == 31) ? 2 : 3;
        case (k)
            0:       r = a[7:0];
            1:       r = 8'(10 * nu * nv);
            2:       r = 8'h80;
            3:       r = 8'h7f;
            default: r = c1_15 ? 8'h00 : 8'hff;
        endcase
        return r;
    endfunction

    int n0;

    task automatic start_sweep(input bit c1_15);
        exp_t e;
        for (int a = 0; a < 1024; a++) begin
            e.addr = 10'(a);
            for (int k = 0; k < ND; k++) e.data[k*8 +: 8] = exp_val(k, a, c1_15);
            exp_q.push_back(e);
        end
        for (int k = 0; k < ND; k++) begin
            we_cnt[k] = 0;
            hv_cnt[k] = 0;
            fd_cnt[k] = 0;
        end
        first_we = -1;
        last_we  = -1;
        hv_cyc   = -1;
        tv = 1'b1;
        @(negedge clk);
        tv = 1'b0;
        n0 = cyc;
        for (int k = 0; k < ND; k++) check("busy_start", k, int'(busy[k]), 1);
    endtask

    task automatic finish_sweep(input int drops);
        while (cyc < n0 + 11264) @(negedge clk);
        for (int k = 0; k < ND; k++) check("busy_in_done", k, int'(busy[k]), 1);
        @(negedge clk);
        for (int k = 0; k < ND; k++) begin
            check("busy_end", k, int'(busy[k]), 0);
            check("write_count", k, we_cnt[k], 1024);
            check("hv_count", k, hv_cnt[k], 1);
            check("drop_count", k, fd_cnt[k], drops);
        end
        check("first_we_cycle", 0, first_we - n0, 10);
        check("last_we_cycle", 0, last_we - n0, 11263);
        check("hv_cycle", 0, hv_cyc - n0, 11264);
        check("queue_left", 0, exp_q.size(), 0);
    endtask

    initial begin
        reset = 1'b1;
        tv    = 1'b0;
        for (int k = 0; k < ND; k++) begin
            we_cnt[k] = 0;
            hv_cnt[k] = 0;
            fd_cnt[k] = 0;
        end
        for (int a = 0; a < 1024; a++) begin
            mem[0][a] = 8'(a);
            mem[1][a] = 8'd10;
            mem[2][a] = 8'd127;
            mem[3][a] = 8'd127;
            mem[4][a] = 8'hff;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < ND; k++) begin
            check("rst_busy", k, int'(busy[k]), 0);
            check("rst_we", k, int'(out_we[k]), 0);
            check("rst_hv", k, int'(hv[k]), 0);
            check("rst_fd", k, int'(fd[k]), 0);
            check("rst_raddr", k, int'(raddr[k]), 0);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Sweep 1 with a dropped tensor_valid sampled at N+500.
        start_sweep(1'b0);
        while (cyc < n0 + 499) @(negedge clk);
        tv = 1'b1;
        @(negedge clk);
        tv = 1'b0;
        for (int k = 0; k < ND; k++) check("frame_drop", k, int'(fd[k]), 1);
        finish_sweep(1);
        repeat (3) @(negedge clk);

        // Sweep 2 aborted by reset.
        start_sweep(1'b0);
        while (cyc < n0 + 2999) @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        for (int k = 0; k < ND; k++) begin
            check("abort_busy", k, int'(busy[k]), 0);
            check("abort_we", k, int'(out_we[k]), 0);
            check("abort_hv", k, int'(hv[k]), 0);
        end
        check("abort_writes", 0, we_cnt[0], 272);
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        for (int k = 0; k < ND; k++) begin
            check("post_abort_hv", k, hv_cnt[k], 0);
            check("post_abort_busy", k, int'(busy[k]), 0);
        end

        // Sweep 3: full sweep after reset, centre-tap input now 15.
        for (int a = 0; a < 1024; a++) mem[4][a] = 8'd15;
        start_sweep(1'b1);
        finish_sweep(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
